addfloat_feeder: RTL and testbench

// - Upstream operand sequencer for the addfloat compute block: buffers 32-bit float operands, issues one
//   run request per operand, waits for the run to finish, then issues the next.
// - Decouples bursty producers from addfloat's one-job-at-a-time busy protocol; sits directly in front of

---
 rtl/addfloat_pkg.sv | 23 ++
 rtl/addfloat_feeder_fifo.sv | 84 ++++++++
 rtl/addfloat_feeder.sv | 156 +++++++++++++++
 tb/tb_addfloat_feeder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addfloat_pkg.sv
`default_nettype none
// ============================================================================
// Package     : addfloat_pkg
// Description : Shared types and widths for the addfloat family of blocks.
//               FLOAT_W    - IEEE-754 single operand width
//               DONE_CNT_W - width of completed-run counters
//               feeder_state_t - sequencing states of addfloat_feeder
// Revision    : 1.0 - initial release
// ============================================================================
package addfloat_pkg;

    localparam int FLOAT_W    = 32;
    localparam int DONE_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } feeder_state_t;

endpackage : addfloat_pkg
`default_nettype wire

// File: rtl/addfloat_feeder_fifo.sv
`default_nettype none
// ============================================================================
// Module      : addfloat_feeder_fifo
// Description : DEPTH x FLOAT_W register FIFO for the addfloat operand feeder.
//               A push into a full FIFO is accepted only when a pop happens
//               in the same cycle; otherwise the data is discarded and o_drop
//               pulses for that cycle. All state updates are qualified by ce.
// Ports       : clock, reset (async, active-high), ce
//               i_push / i_push_data - write request and operand
//               i_pop                - remove head (ignored when empty)
//               o_head               - current head entry
//               o_count              - registered occupancy (0..DEPTH)
//               o_full / o_empty     - occupancy flags
//               o_drop               - combinational pulse: push discarded
// Revision    : 1.0 - initial release
// ============================================================================
module addfloat_feeder_fifo
    import addfloat_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ce,
    input  logic               i_push,
    input  logic [FLOAT_W-1:0] i_push_data,
    input  logic               i_pop,
    output logic [FLOAT_W-1:0] o_head,
    output logic [ADDR_W:0]    o_count,
    output logic               o_full,
    output logic               o_empty,
    output logic               o_drop
);

    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

    logic [FLOAT_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic [ADDR_W:0]    r_count;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push_ok;

    assign w_full    = (r_count == c_depth);
    assign w_empty   = (r_count == '0);
    assign w_pop     = i_pop & ~w_empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_push_ok = i_push & (~w_full | w_pop);

    // Pointers are ADDR_W wide, so DEPTH being a power of two makes them
    // wrap modulo DEPTH on their own.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (ce) begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clock) begin
        if (ce && w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_drop  = ce & i_push & ~w_push_ok;

endmodule : addfloat_feeder_fifo
`default_nettype wire

// File: rtl/addfloat_feeder.sv
`default_nettype none
// ============================================================================
// Module      : addfloat_feeder
// Description : Operand sequencer in front of addfloat's run interface.
//               Buffers float operands and issues one single-cycle run request
//               per operand, waiting for addfloat's busy to rise and fall
//               before issuing the next.
// Ports       : clock, reset (async, active-high), ce (clock enable)
//               i_push / i_push_data       - operand producer side
//               o_full / o_count           - buffer status
//               o_run_req / o_run_input_a_0 - to addfloat run interface
//               i_run_busy                 - from addfloat
//               o_done_cnt                 - completed runs (wrapping)
//               o_overflow / o_timeout     - sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module addfloat_feeder
    import addfloat_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 3,
    parameter int TIMEOUT = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  i_push,
    input  logic [FLOAT_W-1:0]    i_push_data,
    output logic                  o_full,
    output logic [ADDR_W:0]       o_count,
    output logic                  o_run_req,
    output logic [FLOAT_W-1:0]    o_run_input_a_0,
    input  logic                  i_run_busy,
    output logic [DONE_CNT_W-1:0] o_done_cnt,
    output logic                  o_overflow,
    output logic                  o_timeout
);

    // The timer counts low samples of busy; the TIMEOUT-th one gives up.
    localparam logic [7:0] c_timer_last = 8'(TIMEOUT - 1);

    feeder_state_t r_state;
    feeder_state_t w_state_nxt;

    logic                  r_req;
    logic                  w_req_nxt;
    logic [FLOAT_W-1:0]    r_data;
    logic [FLOAT_W-1:0]    w_data_nxt;
    logic [7:0]            r_timer;
    logic [7:0]            w_timer_nxt;
    logic [DONE_CNT_W-1:0] r_done;
    logic [DONE_CNT_W-1:0] w_done_nxt;
    logic                  r_timeout;
    logic                  w_timeout_nxt;
    logic                  r_overflow;

    logic                  w_pop;
    logic [FLOAT_W-1:0]    w_head;
    logic                  w_empty;
    logic                  w_drop;

    addfloat_feeder_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .ce          (ce),
        .i_push      (i_push),
        .i_push_data (i_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (o_count),
        .o_full      (o_full),
        .o_empty     (w_empty),
        .o_drop      (w_drop)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else if (ce) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_req_nxt     = r_req;
        w_data_nxt    = r_data;
        w_timer_nxt   = r_timer;
        w_done_nxt    = r_done;
        w_timeout_nxt = r_timeout;
        w_pop         = 1'b0;
        case (r_state)
            IDLE: begin
                // A busy addfloat (possibly driven by another caller) blocks issue.
                if (!w_empty && !i_run_busy) begin
                    w_pop       = 1'b1;
                    w_req_nxt   = 1'b1;
                    w_data_nxt  = w_head;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                w_req_nxt   = 1'b0;
                w_timer_nxt = '0;
                w_state_nxt = WAIT_HI;
            end
            WAIT_HI: begin
                if (i_run_busy) begin
                    w_state_nxt = WAIT_LO;
                end else if (r_timer == c_timer_last) begin
                    // The operand is abandoned, not retried.
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = IDLE;
                end else begin
                    w_timer_nxt = r_timer + 8'd1;
                end
            end
            WAIT_LO: begin
                if (!i_run_busy) begin
                    w_done_nxt  = r_done + DONE_CNT_W'(1);
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_req      <= 1'b0;
            r_data     <= '0;
            r_timer    <= '0;
            r_done     <= '0;
            r_timeout  <= 1'b0;
            r_overflow <= 1'b0;
        end else if (ce) begin
            r_req      <= w_req_nxt;
            r_data     <= w_data_nxt;
            r_timer    <= w_timer_nxt;
            r_done     <= w_done_nxt;
            r_timeout  <= w_timeout_nxt;
            r_overflow <= r_overflow | w_drop;
        end
    end

    assign o_run_req       = r_req;
    assign o_run_input_a_0 = r_data;
    assign o_done_cnt      = r_done;
    assign o_overflow      = r_overflow;
    assign o_timeout       = r_timeout;

endmodule : addfloat_feeder
`default_nettype wire

// File: tb/tb_addfloat_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_addfloat_feeder
// Description : Directed self-checking bench for addfloat_feeder with a small
//               behavioural model of addfloat's busy handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addfloat_feeder;
    import addfloat_pkg::*;

    localparam int DEPTH   = 8;
    localparam int ADDR_W  = 3;
    localparam int TIMEOUT = 15;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic                  ce = 1'b1;
    logic                  push = 1'b0;
    logic [FLOAT_W-1:0]    push_data = '0;
    logic                  full;
    logic [ADDR_W:0]       count;
    logic                  run_req;
    logic [FLOAT_W-1:0]    run_data;
    logic                  run_busy;
    logic [DONE_CNT_W-1:0] done_cnt;
    logic                  overflow;
    logic                  timeout;

    int n_checks = 0;
    int n_err    = 0;

    // addfloat model: busy rises the edge after it sees a request and stays
    // high for busy_len ce-cycles. force_hi models a foreign caller.
    logic model_en  = 1'b1;
    logic force_hi  = 1'b0;
    logic model_busy;
    int   model_cnt;
    int   busy_len  = 7;

    // Monitor state
    logic        prev_req = 1'b0;
    int          viol = 0;
    logic [31:0] req_log[$];
    int          base;

    always #5 clock = ~clock;

    assign run_busy = force_hi | model_busy;

    addfloat_feeder #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .ce              (ce),
        .i_push          (push),
        .i_push_data     (push_data),
        .o_full          (full),
        .o_count         (count),
        .o_run_req       (run_req),
        .o_run_input_a_0 (run_data),
        .i_run_busy      (run_busy),
        .o_done_cnt      (done_cnt),
        .o_overflow      (overflow),
        .o_timeout       (timeout)
    );

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            model_busy <= 1'b0;
            model_cnt  <= 0;
        end else if (ce) begin
            if (!model_busy) begin
                if (model_en && run_req) begin
                    model_busy <= 1'b1;
                    model_cnt  <= busy_len - 1;
                end
            end else if (model_cnt == 0) begin
                model_busy <= 1'b0;
            end else begin
                model_cnt <= model_cnt - 1;
            end
        end
    end

    always @(posedge clock) begin
        prev_req <= run_req;
        if (run_req && !prev_req) req_log.push_back(run_data);
        if (run_req && run_busy) viol <= viol + 1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input int max);
        int n = 0;
        while (!run_req && n < max) begin
            tick();
            n++;
        end
        check("wait_req", {31'd0, run_req}, 32'd1);
    endtask

    task automatic wait_done(input logic [15:0] target, input int max);
        int n = 0;
        while (done_cnt != target && n < max) begin
            tick();
            n++;
        end
        check("wait_done", {16'd0, done_cnt}, {16'd0, target});
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2 reset = 1'b1;
        #3 reset = 1'b0;
        tick();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_count"},    {28'd0, count},    32'd0);
        check({tag, "_full"},     {31'd0, full},     32'd0);
        check({tag, "_req"},      {31'd0, run_req},  32'd0);
        check({tag, "_data"},     run_data,          32'd0);
        check({tag, "_done"},     {16'd0, done_cnt}, 32'd0);
        check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
        check({tag, "_timeout"},  {31'd0, timeout},  32'd0);
    endtask

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        check_reset_vals("rst");

        // ---------------- single operand, latency ----------------
        push = 1'b1; push_data = 32'h3f80_0000;
        tick();
        push = 1'b0;
        check("t1_count_after_push", {28'd0, count}, 32'd1);
        check("t1_req_t1", {31'd0, run_req}, 32'd0);
        tick();
        check("t1_req_t2", {31'd0, run_req}, 32'd1);
        check("t1_data", run_data, 32'h3f80_0000);
        check("t1_count_after_pop", {28'd0, count}, 32'd0);
        tick();
        check("t1_req_pulse_end", {31'd0, run_req}, 32'd0);
        check("t1_data_held", run_data, 32'h3f80_0000);
        repeat (7) tick();
        check("t1_done_early", {16'd0, done_cnt}, 32'd0);
        tick();
        check("t1_done", {16'd0, done_cnt}, 32'd1);

        // ---------------- three operands in order ----------------
        do_reset();
        base = req_log.size();
        push = 1'b1; push_data = 32'h3f80_0000; tick();
        push_data = 32'h4000_0000; tick();
        push_data = 32'hbf80_0000; tick();
        push = 1'b0;
        wait_done(16'd3, 100);
        check("t2_nreq", req_log.size() - base, 32'd3);
        check("t2_op0", req_log[base+0], 32'h3f80_0000);
        check("t2_op1", req_log[base+1], 32'h4000_0000);
        check("t2_op2", req_log[base+2], 32'hbf80_0000);
        check("t2_count", {28'd0, count}, 32'd0);
        check("t2_viol", viol, 32'd0);

        // ---------------- overflow with busy held ----------------
        do_reset();
        base = req_log.size();
        force_hi = 1'b1;
        for (int i = 0; i < 9; i++) begin
            push = 1'b1; push_data = 32'h4100_0000 + i;
            tick();
            if (i == 7) begin
                check("t3_count8", {28'd0, count}, 32'd8);
                check("t3_full8", {31'd0, full}, 32'd1);
                check("t3_ovf8", {31'd0, overflow}, 32'd0);
            end
        end
        push = 1'b0;
        check("t3_count9", {28'd0, count}, 32'd8);
        check("t3_ovf9", {31'd0, overflow}, 32'd1);
        check("t3_no_req", {31'd0, run_req}, 32'd0);
        force_hi = 1'b0;
        wait_done(16'd8, 200);
        check("t3_nreq", req_log.size() - base, 32'd8);
        check("t3_first", req_log[base+0], 32'h4100_0000);
        check("t3_last", req_log[base+7], 32'h4100_0007);
        check("t3_count_empty", {28'd0, count}, 32'd0);
        check("t3_full_clear", {31'd0, full}, 32'd0);
        check("t3_ovf_sticky", {31'd0, overflow}, 32'd1);

        // ---------------- timeout ----------------
        do_reset();
        model_en = 1'b0;
        push = 1'b1; push_data = 32'h4040_0000; tick();
        push_data = 32'h4080_0000; tick();
        push = 1'b0;
        wait_req(10);
        check("t4_dataA", run_data, 32'h4040_0000);
        repeat (TIMEOUT) tick();
        check("t4_timeout_early", {31'd0, timeout}, 32'd0);
        tick();
        check("t4_timeout", {31'd0, timeout}, 32'd1);
        check("t4_req_low", {31'd0, run_req}, 32'd0);
        tick();
        check("t4_reqB", {31'd0, run_req}, 32'd1);
        check("t4_dataB", run_data, 32'h4080_0000);
        check("t4_done0", {16'd0, done_cnt}, 32'd0);
        model_en = 1'b1;
        wait_done(16'd1, 50);
        check("t4_timeout_sticky", {31'd0, timeout}, 32'd1);

        // ---------------- clock enable freeze ----------------
        do_reset();
        base = req_log.size();
        push = 1'b1; push_data = 32'h40a0_0000; tick();
        push = 1'b0;
        wait_req(10);
        ce = 1'b0;
        repeat (4) begin
            tick();
            check("t5_req_stretched", {31'd0, run_req}, 32'd1);
        end
        check("t5_data_frozen", run_data, 32'h40a0_0000);
        ce = 1'b1;
        tick();
        check("t5_req_dropped", {31'd0, run_req}, 32'd0);
        tick();
        tick();
        ce = 1'b0;
        repeat (4) tick();
        check("t5_done_frozen", {16'd0, done_cnt}, 32'd0);
        check("t5_req_frozen", {31'd0, run_req}, 32'd0);
        check("t5_count_frozen", {28'd0, count}, 32'd0);
        ce = 1'b1;
        wait_done(16'd1, 30);
        repeat (5) tick();
        check("t5_nreq", req_log.size() - base, 32'd1);

        // ---------------- async reset mid-run ----------------
        do_reset();
        for (int i = 0; i < 6; i++) begin
            push = 1'b1; push_data = 32'h4200_0000 + i;
            tick();
        end
        push = 1'b0;
        check("t6_count5", {28'd0, count}, 32'd5);
        #2 reset = 1'b1;
        #1;
        check_reset_vals("t6_async");
        #3 reset = 1'b0;
        base = req_log.size();
        repeat (20) tick();
        check("t6_no_req", req_log.size() - base, 32'd0);
        check("t6_count", {28'd0, count}, 32'd0);
        push = 1'b1; push_data = 32'h40e0_0000; tick();
        push = 1'b0;
        wait_req(10);
        check("t6_new_data", run_data, 32'h40e0_0000);

        check("busy_overlap", viol, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule : tb_addfloat_feeder
`default_nettype wire
